seq_arith_controller: RTL

Parametrised control FSM for the iterative shift/add datapath: sequences WIDTH-bit unsigned shift-add multiply and non-restoring divide with a start/busy/valid handshake. Drives the datapath's load, add/sub, operand select, shift and shift-in bit. Samples the datapath's `sign` status bit each cycle. Sits between the top-level command interface and the accumulator/shift-register datapath.

---
 rtl/arith_ctrl_pkg.sv | 20 ++
 rtl/iter_counter.sv | 29 ++
 rtl/seq_arith_controller.sv | 112 +++++++++++
 3 files changed

// File: rtl/arith_ctrl_pkg.sv
// Shared state encoding, datapath mux selects and mode constants for the shift/add sequencer.
package arith_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    FIX,
    DONE
  } state_t;

  localparam logic [1:0] SEL_IDLE = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;
  localparam logic [1:0] SEL_ITER = 2'b01;
  localparam logic [1:0] SEL_DONE = 2'b00;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

endpackage

// File: rtl/iter_counter.sv
// CW-bit iteration down-counter; clear beats load beats decrement.
module iter_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] init,
  input  logic          load,
  input  logic          dec,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          zero
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= init;
    end else if (dec) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/seq_arith_controller.sv
// Control FSM sequencing WIDTH-bit shift-add multiply and non-restoring divide.
// Outputs decode combinationally from state, latched mode and the live sign bit.
module seq_arith_controller
  import arith_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic          sign,
  input  logic          abort,
  output logic          load,
  output logic          add,
  output logic          sub,
  output logic [1:0]    sel,
  output logic          shift,
  output logic          inbit,
  output logic          busy,
  output logic          valid,
  output logic [CW-1:0] count
);

  state_t state;
  logic   mode_q;
  logic   zero;
  logic   cnt_load;
  logic   cnt_dec;
  logic   cnt_clr;

  // abort is only honoured once a command is in flight
  assign cnt_clr  = abort && (state != IDLE);
  assign cnt_load = (state == LOAD);
  assign cnt_dec  = (state == ITER) && !zero;

  iter_counter #(.CW(CW)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .init  (CW'(WIDTH - 1)),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .clr   (cnt_clr),
    .count (count),
    .zero  (zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      mode_q <= MODE_MUL;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= LOAD;
            mode_q <= mode;
          end
        end
        LOAD:    state <= abort ? IDLE : ITER;
        ITER: begin
          if (abort) begin
            state <= IDLE;
          end else if (zero) begin
            state <= (mode_q == MODE_DIV) ? FIX : DONE;
          end
        end
        FIX:     state <= abort ? IDLE : DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    load  = 1'b0;
    add   = 1'b0;
    sub   = 1'b0;
    shift = 1'b0;
    inbit = 1'b0;
    valid = 1'b0;
    busy  = (state != IDLE);
    sel   = SEL_IDLE;
    case (state)
      LOAD: begin
        load = 1'b1;
        sel  = SEL_LOAD;
      end
      ITER: begin
        sel   = SEL_ITER;
        shift = 1'b1;
        add   = sign;
        // divide: subtract on a non-negative remainder, quotient bit is its complement
        if (mode_q == MODE_DIV) begin
          sub   = ~sign;
          inbit = ~sign;
        end
      end
      FIX: begin
        sel = SEL_ITER;
        add = sign;
      end
      DONE: begin
        sel   = SEL_DONE;
        valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
